// File: rtl/apb_mem_ctrl.sv
// APB4 slave that sequences a byte-lane memory with programmable wait states.
// Optional feature macro: APB_SLVERR_EN (report decode/alignment errors on pslverr).
module apb_mem_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WIDTH   = 8,
    parameter int MEM_DEPTH   = 4,
    parameter int MEM_SIZE    = 256,
    parameter int WAIT_CYCLES = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = {ADDR_WIDTH{1'b0}},
    localparam int MA = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [MEM_DEPTH-1:0]  pstrb,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [MA-1:0]         mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_wr,
    output logic [MEM_DEPTH-1:0]  mem_be
);

    localparam int LANE_BITS = $clog2(MEM_DEPTH);
    localparam int CNT_W     = 4;
    localparam logic [ADDR_WIDTH:0] WINDOW = (ADDR_WIDTH+1)'(MEM_SIZE * MEM_DEPTH);
    localparam logic [CNT_W-1:0]    WAIT_LAST = CNT_W'(WAIT_CYCLES);

    if (DATA_WIDTH != MEM_WIDTH * MEM_DEPTH) begin : g_width_check
        $error("DATA_WIDTH must equal MEM_WIDTH*MEM_DEPTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              wr_r;
    logic              err_r;
    logic              setup_s;
    logic              active_s;
    logic              done_s;
    logic              err_s;
    logic [ADDR_WIDTH:0] off_s;
    logic [MA-1:0]     addr_s;

    assign setup_s  = psel & ~penable;
    assign active_s = psel & penable;
    assign done_s   = active_s & (cnt_r == WAIT_LAST);

    // Address decode: an address below the base wraps to a huge offset, so one compare covers both bounds
    always_comb begin
        off_s  = {1'b0, paddr} - {1'b0, BASE_ADDR};
        addr_s = off_s[LANE_BITS +: MA];
        if (off_s >= WINDOW) begin
            err_s = 1'b1;
        end else if (paddr[LANE_BITS-1:0] != {LANE_BITS{1'b0}}) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Write strobe: only in the completing ACCESS cycle of a clean write, never during reset
    assign mem_wr = ~rst & (state_r == ST_ACCESS) & done_s & wr_r & ~err_r;

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (setup_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!active_s) begin
                    state_s = ST_IDLE;
                end else if (done_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, transfer capture and registered APB/memory outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            wr_r        <= 1'b0;
            err_r       <= 1'b0;
            prdata      <= {DATA_WIDTH{1'b0}};
            pready      <= 1'b0;
            pslverr     <= 1'b0;
            mem_address <= {MA{1'b0}};
            mem_data_in <= {DATA_WIDTH{1'b0}};
            mem_be      <= {MEM_DEPTH{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (setup_s) begin
                        wr_r        <= pwrite;
                        err_r       <= err_s;
                        mem_data_in <= pwdata;
                        mem_be      <= pstrb;
                        mem_address <= addr_s;
                        cnt_r       <= {CNT_W{1'b0}};
                    end
                end
                ST_ACCESS: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (done_s) begin
                        // Writes leave prdata alone; erroneous accesses return zero
                        if (err_r) begin
                            prdata <= {DATA_WIDTH{1'b0}};
                        end else if (!wr_r) begin
                            prdata <= mem_data_out;
                        end
                        pready <= 1'b1;
`ifdef APB_SLVERR_EN
                        pslverr <= err_r;
`else
                        pslverr <= 1'b0;
`endif
                    end
                end
                ST_DONE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    mem_be  <= {MEM_DEPTH{1'b0}};
                end
                default: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// Self-checking bench for apb_mem_ctrl: directed vector table, hand-written
// abort/reset sequences, then random traffic against a word-array reference model.
module tb_apb_mem_ctrl;

    localparam int  WAIT  = 1;
    localparam int  WORDS = 256;
    localparam longint BASE  = 0;
    localparam longint LIMIT = BASE + WORDS * 4;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_wr;
    logic [3:0]  mem_be;

    apb_mem_ctrl #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_WIDTH   (8),
        .MEM_DEPTH   (4),
        .MEM_SIZE    (WORDS),
        .WAIT_CYCLES (WAIT),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pstrb        (pstrb),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_wr       (mem_wr),
        .mem_be       (mem_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-lane memory attached to the controller
    logic [31:0] mem [WORDS];
    logic        mem_clear;
    assign mem_data_out = mem[mem_address];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
        end else if (mem_wr) begin
            for (int l = 0; l < 4; l++)
                if (mem_be[l]) mem[mem_address][8*l +: 8] <= mem_data_in[8*l +: 8];
        end
    end

    // Write-strobe monitor
    int         wr_count;
    logic [7:0] wr_addr_last;
    initial begin
        wr_count = 0;
        wr_addr_last = 8'h0;
    end
    always @(posedge clk) begin
        if (mem_wr) begin
            wr_count     <= wr_count + 1;
            wr_addr_last <= mem_address;
        end
    end

    // Reference model: plain word array, addressed by byte address
    logic [31:0] ref_mem [WORDS];
    int n_checks;
    int n_fail;

    function automatic bit model_err(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la < BASE) || (la >= LIMIT) || ((la % 4) != 0);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((longint'(a) - BASE) / 4);
    endfunction

    function automatic bit exp_slverr(input bit e);
`ifdef APB_SLVERR_EN
        return e;
`else
        return 1'b0 & e;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One APB transfer; called #1 after a rising edge, returns #1 after the edge ending DONE
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic slverr,
                        output int lat, output int pulses, output logic [7:0] pulse_addr);
        int wc0;
        wc0     = wr_count;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        @(posedge clk);
        #1;
        penable = 1'b1;
        lat = 1;
        while (pready !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata      = prdata;
        slverr     = pslverr;
        pulses     = wr_count - wc0;
        pulse_addr = wr_addr_last;
        @(posedge clk);
        #1;
        check("pready_one_cycle", 32'(pready), 32'h0);
        check("pslverr_cleared", 32'(pslverr), 32'h0);
        check("mem_be_cleared", 32'(mem_be), 32'h0);
    endtask

    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input bit use_tab,
                          input logic [31:0] tab_rd, input bit tab_err);
        logic [31:0] rd;
        logic        se;
        int          lat;
        int          pulses;
        logic [7:0]  pa;
        bit          e;
        logic [31:0] exp_rd;
        int          idx;
        e      = use_tab ? tab_err : model_err(addr);
        idx    = e ? 0 : model_idx(addr);
        exp_rd = e ? 32'h0 : ref_mem[idx];
        if (use_tab) exp_rd = tab_rd;
        xfer(wr, addr, wdata, strb, rd, se, lat, pulses, pa);
        check("latency", 32'(lat), 32'(WAIT + 2));
        check("pslverr", 32'(se), 32'(exp_slverr(e)));
        check("mem_wr_pulses", 32'(pulses), (wr && !e) ? 32'h1 : 32'h0);
        if (!wr) check("prdata", rd, exp_rd);
        if (wr && !e) begin
            check("mem_address", 32'(pa), 32'(idx));
            for (int l = 0; l < 4; l++)
                if (strb[l]) ref_mem[idx][8*l +: 8] = wdata[8*l +: 8];
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] saved;
        int          wc0;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hA5A5_1234, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h5, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h00FF_00FF, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0013, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hA5A5_1234, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_03FD, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[12] = '{1'b1, 32'h0000_0024, 32'h1122_3344, 4'h0, 32'h0,         1'b0};
        vecs[13] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'h0,         1'b0};
        vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};

        rst = 1'b1; mem_clear = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_mem_address", 32'(mem_address), 32'h0);
        check("rst_mem_data_in", mem_data_in, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        rst = 1'b0; mem_clear = 1'b0;
        idle(1);

        // Directed table, all transfers back-to-back
        for (int i = 0; i < 15; i++)
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                   1'b1, vecs[i].exp_rdata, vecs[i].exp_err);

        // Abort: select dropped right after the setup phase
        idle(1);
        saved = prdata;
        wc0   = wr_count;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h30; pwdata = 32'h7777_7777; pstrb = 4'hF;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check("abort_pready", 32'(pready), 32'h0);
        end
        check("abort_no_write", 32'(wr_count - wc0), 32'h0);
        check("abort_prdata_hold", prdata, saved);
        do_txn(1'b0, 32'h30, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);

        // Reset asserted in the completion cycle of a write to 0x50
        idle(1);
        wc0 = wr_count;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h50; pwdata = 32'h5A5A_5A5A; pstrb = 4'hF;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        check("completion_mem_wr", 32'(mem_wr), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_gates_mem_wr", 32'(mem_wr), 32'h0);
        @(posedge clk);
        #1;
        check("midrst_pready", 32'(pready), 32'h0);
        check("midrst_pslverr", 32'(pslverr), 32'h0);
        check("midrst_prdata", prdata, 32'h0);
        check("midrst_mem_be", 32'(mem_be), 32'h0);
        check("midrst_mem_address", 32'(mem_address), 32'h0);
        check("midrst_no_write", 32'(wr_count - wc0), 32'h0);
        rst = 1'b0;
        idle(1);
        do_txn(1'b0, 32'h50, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);

        // Random traffic against the reference model
        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h400 + ($urandom_range(0, 4095) * 4);
            else if (sel == 1) a = (32'($urandom_range(0, 255)) * 4) + 32'($urandom_range(1, 3));
            else if (sel < 6)  a = 32'($urandom_range(0, 15)) * 4;
            else               a = 32'($urandom_range(240, 255)) * 4;
            do_txn($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
                   1'b0, 32'h0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
